// File: rtl/logic_pkg.sv
// Shared constants for the datapath logic unit: opcode encoding and
// the width helper for population-count results.
package logic_pkg;

    localparam int OP_W = 3;

    // 000/001 keep the legacy 1-bit OP meaning (0=OR, 1=AND).
    localparam logic [OP_W-1:0] LOP_OR   = 3'b000;
    localparam logic [OP_W-1:0] LOP_AND  = 3'b001;
    localparam logic [OP_W-1:0] LOP_XOR  = 3'b010;
    localparam logic [OP_W-1:0] LOP_NOR  = 3'b011;
    localparam logic [OP_W-1:0] LOP_NAND = 3'b100;
    localparam logic [OP_W-1:0] LOP_XNOR = 3'b101;
    localparam logic [OP_W-1:0] LOP_NOTA = 3'b110;
    localparam logic [OP_W-1:0] LOP_ANDN = 3'b111;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/logic_unit_pipe_popcount.sv
// Combinational population count built as a balanced binary adder tree
// over the input bits, padded with zero leaves up to a power of two.
module popcount #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = logic_pkg::cnt_width(WIDTH)
) (
    input  logic [WIDTH-1:0] x,
    output logic [CNT_W-1:0] cnt
);
    localparam int LEAVES = 1 << $clog2(WIDTH);

    // Heap-ordered nodes: node 1 is the root, leaves sit at LEAVES..2*LEAVES-1.
    for (genvar k = 1; k < 2 * LEAVES; k++) begin : g_node
        logic [CNT_W-1:0] sum;
        if (k >= LEAVES) begin : g_leaf
            if (k - LEAVES < WIDTH) begin : g_bit
                assign sum = CNT_W'(x[k-LEAVES]);
            end else begin : g_pad
                assign sum = '0;
            end
        end else begin : g_add
            assign sum = g_node[2*k].sum + g_node[2*k+1].sum;
        end
    end

    assign cnt = g_node[1].sum;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshake.
// S1 holds the raw result, S2 holds the result plus zero/parity/popcount flags.
module logic_unit_pipe #(
    parameter  int WIDTH = 8,
    parameter  int OP_W  = 3,
    localparam int CNT_W = logic_pkg::cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_popcnt
);
    import logic_pkg::*;

    if (OP_W != 3 || WIDTH < 2) begin : g_bad_param
        $error("logic_unit_pipe: OP_W must be 3 and WIDTH >= 2");
    end

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             zero;
        logic             parity;
        logic [CNT_W-1:0] popcnt;
    } res_t;

    function automatic logic [WIDTH-1:0] logic_op(input logic [OP_W-1:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (op)
            LOP_OR:   return a | b;
            LOP_AND:  return a & b;
            LOP_XOR:  return a ^ b;
            LOP_NOR:  return ~(a | b);
            LOP_NAND: return ~(a & b);
            LOP_XNOR: return ~(a ^ b);
            LOP_NOTA: return ~a;
            LOP_ANDN: return a & ~b;
            default:  return '0;
        endcase
    endfunction

    logic             s1_valid, s2_valid;
    logic             s1_ready, s2_ready;
    logic [WIDTH-1:0] s1_y;
    logic [CNT_W-1:0] s1_cnt;
    res_t             s2_q;

    assign s2_ready = !s2_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready && !reset;

    // Flags are computed between stages so S2 outputs come straight from flops.
    popcount #(.WIDTH(WIDTH)) u_popcount (
        .x   (s1_y),
        .cnt (s1_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_y     <= '0;
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else begin
            if (s1_ready) begin
                s1_valid <= in_valid;
                if (in_valid) s1_y <= logic_op(in_op, in_a, in_b);
            end
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_q <= '{y: s1_y, zero: (s1_cnt == '0),
                              parity: s1_cnt[0], popcnt: s1_cnt};
                end
            end
        end
    end

    assign out_valid  = s2_valid;
    assign out_y      = s2_q.y;
    assign out_zero   = s2_q.zero;
    assign out_parity = s2_q.parity;
    assign out_popcnt = s2_q.popcnt;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: 8-bit instance for ops, latency,
// back-pressure and reset; 32-bit instance for the wide corner case.
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_a, in_b, out_y;
    logic [2:0] in_op;
    logic       out_zero, out_parity;
    logic [3:0] out_popcnt;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [31:0] w_in_a, w_in_b, w_out_y;
    logic [2:0]  w_in_op;
    logic        w_out_zero, w_out_parity;
    logic [5:0]  w_out_popcnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] y;
        logic       zero;
        logic       parity;
        logic [3:0] pc;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_zero(out_zero),
        .out_parity(out_parity), .out_popcnt(out_popcnt)
    );

    logic_unit_pipe #(.WIDTH(32)) dut_w (
        .clk(clk), .reset(reset),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_a(w_in_a), .in_b(w_in_b), .in_op(w_in_op),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_y(w_out_y), .out_zero(w_out_zero),
        .out_parity(w_out_parity), .out_popcnt(w_out_popcnt)
    );

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [2:0] op);
        exp_t e;
        case (op)
            3'd0: e.y = a | b;
            3'd1: e.y = a & b;
            3'd2: e.y = a ^ b;
            3'd3: e.y = ~(a | b);
            3'd4: e.y = ~(a & b);
            3'd5: e.y = ~(a ^ b);
            3'd6: e.y = ~a;
            default: e.y = a & ~b;
        endcase
        e.pc     = 4'($countones(e.y));
        e.zero   = (e.y == 8'h00);
        e.parity = ^e.y;
        return e;
    endfunction

    // Drive one beat from posedge+1; returns posedge+1 after it is accepted.
    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(a, b, op));
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
        end
        checks++; failures++;
        $display("FAIL drive_timeout: in_ready never high for op=%0d", op);
        in_valid = 1'b0;
    endtask

    task automatic compare_head(input string tag);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_unexpected: got y=%h with empty scoreboard", tag, out_y);
            return;
        end
        e = exp_q.pop_front();
        if (out_y !== e.y || out_zero !== e.zero || out_parity !== e.parity ||
            out_popcnt !== e.pc) begin
            failures++;
            $display("FAIL %s_result: got y=%h z=%b p=%b pc=%0d, want y=%h z=%b p=%b pc=%0d",
                     tag, out_y, out_zero, out_parity, out_popcnt,
                     e.y, e.zero, e.parity, e.pc);
        end
    endtask

    // Collect n results; optionally demand they arrive on consecutive cycles.
    task automatic collect(input int n, input bit consec, input string tag);
        int   got = 0;
        bit   stalled = 1'b0;
        logic [7:0] held = '0;
        for (int t = 0; t < 2000 && got < n; t++) begin
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_y !== held) begin
                    failures++;
                    $display("FAIL %s_hold: got v=%b y=%h, want v=1 y=%h",
                             tag, out_valid, out_y, held);
                end
            end
            stalled = out_valid && !out_ready;
            held    = out_y;
            if (out_valid && out_ready) begin
                compare_head(tag);
                got++;
            end else if (consec && got > 0) begin
                checks++; failures++;
                $display("FAIL %s_gap: bubble after %0d results, want none", tag, got);
            end
        end
        if (got < n) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got %0d results, want %0d", tag, got, n);
        end
    endtask

    // Single beat with out_ready high: valid exactly two cycles after acceptance.
    task automatic run_single(input logic [7:0] a, input logic [7:0] b,
                              input logic [2:0] op, input string tag);
        drive(a, b, op);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_lat1: out_valid=%b, want 0", tag, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_lat2: out_valid=%b, want 1", tag, out_valid);
        end else begin
            compare_head(tag);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_drain: out_valid=%b, want 0", tag, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_op = '0;
        w_in_valid = 1'b0; w_out_ready = 1'b1;
        w_in_a = '0; w_in_b = '0; w_in_op = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_y !== 8'h00 ||
            out_popcnt !== 4'd0 || out_zero !== 1'b0 || out_parity !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: rdy=%b v=%b y=%h pc=%0d z=%b p=%b, want all 0",
                     in_ready, out_valid, out_y, out_popcnt, out_zero, out_parity);
        end
        checks++;
        if (w_in_ready !== 1'b0 || w_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_wide: rdy=%b v=%b, want 0 0", w_in_ready, w_out_valid);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: rdy=%b v=%b, want 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        run_single(8'hF0, 8'h3C, 3'd0, "or");
        run_single(8'hF0, 8'h3C, 3'd1, "and");
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        fork
            begin
                drive(8'hF0, 8'h3C, 3'd2);
                drive(8'hF0, 8'h3C, 3'd3);
                drive(8'hF0, 8'h3C, 3'd4);
                drive(8'hF0, 8'h3C, 3'd5);
            end
            collect(4, 1'b1, "b2b");
        join
        @(posedge clk); #1;
    endtask

    task automatic test_edge_ops;
        out_ready = 1'b1;
        run_single(8'hF0, 8'h0F, 3'd1, "zero");
        run_single(8'hF0, 8'h0F, 3'd6, "nota");
        run_single(8'hF0, 8'h0F, 3'd7, "andn");
        run_single(8'hFF, 8'h00, 3'd0, "allones");
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(8'hF0, 8'h3C, 3'd0);
        drive(8'hF0, 8'h3C, 3'd1);
        in_valid = 1'b1; in_a = 8'hF0; in_b = 8'h3C; in_op = 3'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_y !== 8'hFC) begin
                failures++;
                $display("FAIL bp_full: rdy=%b v=%b y=%h, want rdy=0 v=1 y=fc",
                         in_ready, out_valid, out_y);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        fork
            drive(8'hF0, 8'h3C, 3'd2);
            collect(3, 1'b1, "bp_drain");
        join
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset;
        out_ready = 1'b0;
        drive(8'hF0, 8'h3C, 3'd0);
        drive(8'hF0, 8'h3C, 3'd1);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_ready: in_ready=%b during reset, want 0", in_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_y !== 8'h00 || out_popcnt !== 4'd0 ||
            in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_clear: v=%b y=%h pc=%0d rdy=%b, want 0 00 0 1",
                     out_valid, out_y, out_popcnt, in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        run_single(8'hF0, 8'h3C, 3'd2, "midrst_next");
    endtask

    task automatic test_random;
        bit done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    drive(8'($urandom), 8'($urandom), 3'($urandom));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
            end
            begin
                collect(60, 1'b0, "rand");
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_wide;
        logic [31:0] ey;
        w_in_a = 32'hFFFF_FFFF; w_in_b = 32'h0000_0001; w_in_op = 3'd7;
        ey = w_in_a & ~w_in_b;
        w_in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (w_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL wide_ready: in_ready=%b, want 1", w_in_ready);
        end
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (w_out_valid !== 1'b1 || w_out_y !== ey ||
            w_out_popcnt !== 6'($countones(ey)) || w_out_parity !== ^ey ||
            w_out_zero !== 1'b0) begin
            failures++;
            $display("FAIL wide_result: v=%b y=%h pc=%0d p=%b z=%b, want 1 %h %0d %b 0",
                     w_out_valid, w_out_y, w_out_popcnt, w_out_parity, w_out_zero,
                     ey, $countones(ey), ^ey);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_edge_ops();
        test_backpressure();
        test_mid_reset();
        test_random();
        test_wide();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: %0d entries, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
